// File: rtl/shift_stage_pkg.sv
// Shared types for the shift_stage operand-shaping block.
package shift_stage_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [2:0] {
        OP_SHL  = 3'd0,
        OP_SHR  = 3'd1,
        OP_ASHL = 3'd2,
        OP_ASHR = 3'd3,
        OP_ADD  = 3'd4,
        OP_NOT  = 3'd5,
        OP_LNOT = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Opcodes 0-3 are the iterative shifts.
    function automatic logic is_shift(input op_e op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/shift_stage_step.sv
// One combinational step: a single-bit shift, or a complete add/invert.
module shift_stage_step
    import shift_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, value} + {1'b0, b};

    always_comb begin
        next  = value;
        carry = 1'b0;
        case (op)
            OP_SHL, OP_ASHL: next = {value[WIDTH-2:0], 1'b0};
            OP_SHR:          next = {1'b0, value[WIDTH-1:1]};
            OP_ASHR:         next = {value[WIDTH-1], value[WIDTH-1:1]};
            OP_ADD: begin
                next  = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_NOT:          next = ~value;
            OP_LNOT: begin
                next    = '0;
                next[0] = (value == '0);
            end
            default:         next = value;
        endcase
    end

endmodule

// File: rtl/shift_stage.sv
// Operand-shaping stage: accepts one command, iterates shifts one bit per
// clock, and holds the x/y result on a valid/ready port.
//
// state | meaning
// IDLE  | ready for a command
// RUN   | iterating a shift, count = steps remaining
// HOLD  | result presented, waiting for out_ready
module shift_stage
    import shift_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [CNT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);

    state_e           state_q, state_d;
    op_e              op_q;
    op_e              cmd_op;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] work_q;

    op_e              step_op;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] step_next;
    logic             step_carry;

    logic accept;
    logic start_run;
    logic last_step;

    assign cmd_op    = op_e'(in_op);
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    assign accept    = in_valid && in_ready;
    assign start_run = accept && is_shift(cmd_op) && (in_amt != '0);
    assign last_step = (state_q == RUN) && (count_q == CNT_W'(1));

    // The step unit sees the incoming command in IDLE and the working value in RUN.
    assign step_op    = (state_q == IDLE) ? cmd_op : op_q;
    assign step_value = (state_q == IDLE) ? in_a : work_q;

    shift_stage_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op    (step_op),
        .value (step_value),
        .b     (in_b),
        .next  (step_next),
        .carry (step_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = start_run ? RUN : HOLD;
            RUN:  if (last_step) state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_SHL;
            count_q <= '0;
            work_q  <= '0;
            out_x   <= '0;
            out_y   <= '0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                out_y <= (cmd_op == OP_ADD) ? {{(WIDTH-1){1'b0}}, step_carry} : in_b;
                if (start_run) begin
                    work_q  <= in_a;
                    count_q <= in_amt;
                end else begin
                    // A zero-length shift passes the operand through untouched.
                    out_x <= is_shift(cmd_op) ? in_a : step_next;
                end
            end
            if (state_q == RUN) begin
                work_q  <= step_next;
                count_q <= count_q - CNT_W'(1);
                if (last_step) out_x <= step_next;
            end
        end
    end

endmodule

// File: doc/shift_stage.md
Name: shift_stage

Overview:
- Sequential operand-shaping stage that produces the 9-bit `x`/`y` operand pair consumed by the downstream shift/logic consumer block.
- Accepts one command per handshake: opcode, two operands and a shift amount.
- Shifts execute iteratively, one bit per clock. Add and invert execute in a single cycle.
- Holds the result on a valid/ready output until the consumer takes it.

Parameters:
- WIDTH, 9: operand and result width.
- CNT_W, 4: width of the shift-amount field; maximum iteration count is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  command present
- in_ready  output  1  stage can accept a command
- in_op  input  3  opcode
- in_a  input  WIDTH  primary operand
- in_b  input  WIDTH  secondary operand
- in_amt  input  CNT_W  shift amount
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_x  output  WIDTH  primary result
- out_y  output  WIDTH  secondary result
- busy  output  1  state != IDLE

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset `rst_n` is synchronous and active-low; it is sampled only on the rising edge of `clk`.
  - While `rst_n`=0 at an edge: state <= IDLE, out_valid=0, out_x=0, out_y=0, count=0.
  - in_ready = (state==IDLE) && rst_n, so in_ready=0 while reset is asserted.
  - Reset asserted mid-RUN or mid-HOLD discards the command; no output is produced.
- Opcodes:
  - 0 SHL: logical `<<` by 1 per iteration.
  - 1 SHR: logical `>>` by 1 per iteration.
  - 2 ASHL: `<<<` by 1 per iteration; identical result to SHL.
  - 3 ASHR: `>>>` by 1 per iteration; MSB is replicated.
  - 4 ADD: out_x = (a+b) mod 2^WIDTH; out_y = {0..., carry}.
  - 5 NOT: out_x = ~a.
  - 6 LNOT: out_x = !a, zero-extended (1 if a==0, else 0).
  - 7 reserved: out_x = a.
  - For opcodes 0-3 and 5-7, out_y = b as captured at acceptance.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture op/a/b/amt.
    - Shift op with amt!=0: go to RUN with count=amt and working register=a.
    - Otherwise: compute the result, load out_x/out_y, go to HOLD.
  - RUN: each cycle, working register <= one-bit step; count <= count-1. When count reaches 1 (final step this cycle), load out_x and go to HOLD. in_ready=0.
  - HOLD: out_valid=1; out_x/out_y are stable. When out_ready=1, go to IDLE and clear out_valid. No accept is bypassed in the same cycle; the next command is accepted one cycle later.
- Latency, measured from the accept edge (cycle 0):
  - out_valid rises at cycle 1 for ADD/NOT/LNOT/reserved, and for shifts with amt=0.
  - out_valid rises at cycle amt+1 for shifts with amt>0.
- Throughput: at most one command per (latency+1) cycles with out_ready held at 1.
- Boundaries:
  - amt >= WIDTH: SHL/SHR/ASHL yield 0; ASHR yields all-ones if a[MSB]=1, else 0. Iteration still runs the full amt cycles.
  - ADD overflow wraps modulo 2^WIDTH; carry is reported only in out_y[0].
  - in_valid asserted while in_ready=0 is ignored; the upstream stage must hold it.
  - out_ready asserted while out_valid=0 has no effect.
- The outputs in_ready, out_valid and busy are glitch-free functions of registered state, plus rst_n in the case of in_ready.

Decomposition:
- Package shift_stage_pkg:
  - op enum with OP_SHL=0, OP_SHR=1, OP_ASHL=2, OP_ASHR=3, OP_ADD=4, OP_NOT=5, OP_LNOT=6, OP_RSVD=7.
  - state enum with IDLE, RUN, HOLD.
- Sub-module shift_stage_step: combinational one-step unit that takes (op, value, b) and returns the next value plus carry. It is used both for single-cycle ops and for each RUN iteration.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, out_x=0, in_ready=0. Release -> in_ready=1 on the next cycle.
- SHL a=9'h0FF, amt=3 -> out_valid at cycle 4 with out_x=9'h1F8; SHR a=9'h100, amt=8 -> out_x=9'h001 at cycle 9.
- ASHR a=9'h180, amt=12 -> out_x=9'h1FF; SHR with the same inputs -> 9'h000.
- ADD a=9'h1FF, b=9'h002 -> cycle 1: out_x=9'h001, out_y=9'h001. LNOT a=0 -> out_x=9'h001. NOT a=9'h0F0 -> out_x=9'h10F.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_x stable and in_ready=0; new in_valid is ignored. Raise out_ready -> IDLE next cycle.
- Drop rst_n during RUN (amt=10, after 4 steps) -> next edge IDLE, out_valid=0. A new command after release completes normally.
